cnn_conv_datapath: RTL and testbench

Convolution datapath stage directly downstream of the CNN frame-control FSM. It turns the FSM's per-cycle scan position (row, col, 3x3 tap index) into read requests to the input-feature SRAM. Padding taps are zeroed, and nine signed-weight products are accumulated per output pixel. Each finished pixel is written back as bias-added, shifted, ReLU'd and saturated 8-bit data, with its output address.

---
 rtl/cnn_conv_datapath_pkg.sv | 27 ++
 rtl/cnn_conv_datapath_tap_addr.sv | 57 +++++
 rtl/cnn_conv_datapath.sv | 158 +++++++++++++++
 tb/tb_cnn_conv_datapath.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_conv_datapath_pkg.sv
// Shared constants and sideband types for the convolution datapath.
// Tap indices are row-major over a 3x3 window; pixels are unsigned 8-bit.
package cnn_conv_datapath_pkg;

   localparam int TAP_LAST   = 8;
   localparam int TAP_CENTER = 4;
   localparam int DEF_W_ACC  = 24;
   localparam int PIX_MAX    = 255;

   // Per-tap sideband carried alongside the SRAM access.
   typedef struct packed {
      logic              valid;
      logic              pad;
      logic              first;
      logic              last;
      logic              end_frame;
      logic signed [7:0] w;
   } tap_sb_t;

   // Window row (0..2) of a 3x3 tap index.
   function automatic logic [1:0] tap_row(input logic [3:0] idx);
      if (idx < 4'd3)      return 2'd0;
      else if (idx < 4'd6) return 2'd1;
      else                 return 2'd2;
   endfunction

endpackage

// File: rtl/cnn_conv_datapath_tap_addr.sv
// Combinational decode of (row, col, tap) into neighbour address and pad flag.
// Neighbour coordinates are signed so that the -1 offsets at the borders are detectable.
module cnn_tap_addr
   import cnn_conv_datapath_pkg::*;
#(
   parameter int W_SIZE = 12,
   parameter int W_ADDR = 24
) (
   input  logic [W_SIZE-1:0] row_i,
   input  logic [W_SIZE-1:0] col_i,
   input  logic [3:0]        pix_idx_i,
   input  logic              is_conv3x3_i,
   input  logic [W_SIZE-1:0] width_i,
   input  logic [W_SIZE-1:0] height_i,
   output logic [W_ADDR-1:0] addr_o,
   output logic              pad_o,
   output logic              first_o,
   output logic              last_o,
   output logic [3:0]        tap_o
);

   logic [1:0]          dr_idx;
   logic [3:0]          dc_full;
   logic signed [2:0]   dr_off;
   logic signed [2:0]   dc_off;
   logic signed [W_SIZE:0] r_s;
   logic signed [W_SIZE:0] c_s;
   logic [W_SIZE-1:0]   r_u;
   logic [W_SIZE-1:0]   c_u;

   always_comb begin
      dr_idx  = tap_row(pix_idx_i);
      dc_full = pix_idx_i - 4'({dr_idx, 1'b0}) - 4'(dr_idx);
      dr_off  = $signed({1'b0, dr_idx}) - 3'sd1;
      dc_off  = $signed({1'b0, dc_full[1:0]}) - 3'sd1;
      if (is_conv3x3_i) begin
         r_s     = $signed({1'b0, row_i}) + $signed({{(W_SIZE-2){dr_off[2]}}, dr_off});
         c_s     = $signed({1'b0, col_i}) + $signed({{(W_SIZE-2){dc_off[2]}}, dc_off});
         pad_o   = (r_s < 0) || (c_s < 0) ||
                   (r_s >= $signed({1'b0, height_i})) || (c_s >= $signed({1'b0, width_i}));
         first_o = (pix_idx_i == 4'd0);
         last_o  = (pix_idx_i == 4'(TAP_LAST));
         tap_o   = pix_idx_i;
      end else begin
         r_s     = $signed({1'b0, row_i});
         c_s     = $signed({1'b0, col_i});
         pad_o   = 1'b0;
         first_o = 1'b1;
         last_o  = 1'b1;
         tap_o   = 4'(TAP_CENTER);
      end
      r_u    = r_s[W_SIZE-1:0];
      c_u    = c_s[W_SIZE-1:0];
      addr_o = pad_o ? '0 : (W_ADDR'(r_u) * W_ADDR'(width_i) + W_ADDR'(c_u));
   end

endmodule

// File: rtl/cnn_conv_datapath.sv
// Three-stage tap pipeline: address/weight select, SRAM access, MAC + output clamp.
// A pixel's result leaves three cycles after its last tap; no backpressure anywhere.
module cnn_conv_datapath
   import cnn_conv_datapath_pkg::*;
#(
   parameter int W_SIZE = 12,
   parameter int W_ADDR = 24,
   parameter int W_ACC  = DEF_W_ACC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ctrl_data_run,
   input  logic [W_SIZE-1:0] i_row,
   input  logic [W_SIZE-1:0] i_col,
   input  logic [3:0]        i_pix_idx,
   input  logic              i_end_frame,
   input  logic              q_is_conv3x3,
   input  logic [W_SIZE-1:0] q_width,
   input  logic [W_SIZE-1:0] q_height,
   input  logic [71:0]       q_weight,
   input  logic [15:0]       q_bias,
   input  logic [3:0]        q_shift,
   output logic              o_rd_en,
   output logic [W_ADDR-1:0] o_rd_addr,
   input  logic [7:0]        i_rd_data,
   output logic              o_wr_en,
   output logic [W_ADDR-1:0] o_wr_addr,
   output logic [7:0]        o_wr_data,
   output logic              o_frame_done
);

   logic [W_ADDR-1:0] tap_addr;
   logic              tap_pad;
   logic              tap_first;
   logic              tap_last;
   logic [3:0]        tap_sel;
   logic signed [7:0] w_sel;
   logic [W_ADDR-1:0] pix_addr;

   cnn_tap_addr #(
      .W_SIZE (W_SIZE),
      .W_ADDR (W_ADDR)
   ) u_tap_addr (
      .row_i        (i_row),
      .col_i        (i_col),
      .pix_idx_i    (i_pix_idx),
      .is_conv3x3_i (q_is_conv3x3),
      .width_i      (q_width),
      .height_i     (q_height),
      .addr_o       (tap_addr),
      .pad_o        (tap_pad),
      .first_o      (tap_first),
      .last_o       (tap_last),
      .tap_o        (tap_sel)
   );

   always_comb begin
      w_sel = '0;
      for (int k = 0; k <= TAP_LAST; k++) begin
         if (tap_sel == 4'(k)) w_sel = $signed(q_weight[8*k +: 8]);
      end
      pix_addr = W_ADDR'(i_row) * W_ADDR'(q_width) + W_ADDR'(i_col);
   end

   // Stage A: read request plus sideband for the tap.
   tap_sb_t           a_q;
   logic [W_ADDR-1:0] a_addr_q;
   logic              rd_en_q;
   logic [W_ADDR-1:0] rd_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         a_addr_q  <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         a_q.valid <= i_ctrl_data_run;
         rd_en_q   <= i_ctrl_data_run & ~tap_pad;
         if (i_ctrl_data_run) begin
            a_q.pad       <= tap_pad;
            a_q.first     <= tap_first;
            a_q.last      <= tap_last;
            a_q.end_frame <= i_end_frame;
            a_q.w         <= w_sel;
            a_addr_q      <= pix_addr;
            rd_addr_q     <= tap_addr;
         end
      end
   end

   // Stage B: sideband waits one cycle for the SRAM data.
   tap_sb_t           b_q;
   logic [W_ADDR-1:0] b_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_q      <= '0;
         b_addr_q <= '0;
      end else begin
         b_q      <= a_q;
         b_addr_q <= a_addr_q;
      end
   end

   // Stage C: multiply-accumulate; the first tap reloads with the bias.
   logic [7:0]              pix;
   logic signed [16:0]      prod;
   logic signed [W_ACC-1:0] prod_ext;
   logic signed [W_ACC-1:0] bias_ext;
   logic signed [W_ACC-1:0] acc_q;
   logic signed [W_ACC-1:0] acc_d;
   logic signed [W_ACC-1:0] shifted;
   logic [7:0]              clamp_pix;

   always_comb begin
      pix      = b_q.pad ? 8'd0 : i_rd_data;
      prod     = $signed({1'b0, pix}) * b_q.w;
      prod_ext = {{(W_ACC-17){prod[16]}}, prod};
      bias_ext = {{(W_ACC-16){q_bias[15]}}, q_bias};
      acc_d    = b_q.first ? (prod_ext + bias_ext) : (acc_q + prod_ext);
      shifted  = acc_d >>> q_shift;
      if (shifted < 0)                               clamp_pix = 8'd0;
      else if (shifted > $signed(W_ACC'(PIX_MAX)))   clamp_pix = 8'(PIX_MAX);
      else                                           clamp_pix = shifted[7:0];
   end

   logic              wr_en_q;
   logic [W_ADDR-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              frame_done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (b_q.valid) acc_q <= acc_d;
         wr_en_q      <= b_q.valid & b_q.last;
         frame_done_q <= b_q.valid & b_q.last & b_q.end_frame;
         if (b_q.valid & b_q.last) begin
            wr_addr_q <= b_addr_q;
            wr_data_q <= clamp_pix;
         end
      end
   end

   assign o_rd_en      = rd_en_q;
   assign o_rd_addr    = rd_addr_q;
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_conv_datapath.sv
// Directed bench for cnn_conv_datapath with a one-cycle-latency SRAM model
// and a negedge monitor that logs every written pixel.
module tb_cnn_conv_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [11:0] row, col;
   logic [3:0]  pix_idx;
   logic        end_frame;
   logic        is_conv3x3;
   logic [11:0] width, height;
   logic [71:0] weight;
   logic [15:0] bias;
   logic [3:0]  shift;
   logic        rd_en;
   logic [23:0] rd_addr;
   logic [7:0]  rd_data;
   logic        wr_en;
   logic [23:0] wr_addr;
   logic [7:0]  wr_data;
   logic        frame_done;

   cnn_conv_datapath dut (
      .clk             (clk),
      .rst             (rst),
      .i_ctrl_data_run (run),
      .i_row           (row),
      .i_col           (col),
      .i_pix_idx       (pix_idx),
      .i_end_frame     (end_frame),
      .q_is_conv3x3    (is_conv3x3),
      .q_width         (width),
      .q_height        (height),
      .q_weight        (weight),
      .q_bias          (bias),
      .q_shift         (shift),
      .o_rd_en         (rd_en),
      .o_rd_addr       (rd_addr),
      .i_rd_data       (rd_data),
      .o_wr_en         (wr_en),
      .o_wr_addr       (wr_addr),
      .o_wr_data       (wr_data),
      .o_frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   initial rd_data = 8'd0;
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[7:0]];

   int wr_addr_log[$];
   int wr_data_log[$];
   int wr_fd_log[$];
   int rd_cnt;
   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (wr_en) begin
         wr_addr_log.push_back(int'(wr_addr));
         wr_data_log.push_back(int'(wr_data));
         wr_fd_log.push_back(int'(frame_done));
      end
      if (rd_en) rd_cnt++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      wr_fd_log.delete();
      rd_cnt = 0;
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < 256; i++) mem[i] = 8'(v);
   endtask

   task automatic set_weights(input int w);
      for (int k = 0; k < 9; k++) weight[8*k +: 8] = 8'(w);
   endtask

   task automatic drive_tap(input int r, input int c, input int idx, input bit ef);
      @(negedge clk);
      run       = 1'b1;
      row       = 12'(r);
      col       = 12'(c);
      pix_idx   = 4'(idx);
      end_frame = ef;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         run       = 1'b0;
         end_frame = 1'b0;
      end
   endtask

   task automatic pixel3(input int r, input int c, input bit ef);
      for (int k = 0; k < 9; k++) drive_tap(r, c, k, ef);
   endtask

   // Expects exactly one written pixel in the log.
   task automatic check_one(input string tag, input int a, input int d, input int fd);
      check({tag, "_count"}, wr_data_log.size(), 1);
      if (wr_data_log.size() >= 1) begin
         check({tag, "_addr"}, wr_addr_log[0], a);
         check({tag, "_data"}, wr_data_log[0], d);
         check({tag, "_fd"}, wr_fd_log[0], fd);
      end
   endtask

   int frame_exp[16];

   initial begin
      rst = 1'b1; run = 1'b0; row = '0; col = '0; pix_idx = '0; end_frame = 1'b0;
      is_conv3x3 = 1'b1; width = 12'd4; height = 12'd4;
      weight = '0; bias = '0; shift = '0;
      fill(10);
      set_weights(1);
      rd_cnt = 0;

      repeat (3) @(negedge clk);
      check("rst_rd_en", int'(rd_en), 0);
      check("rst_rd_addr", int'(rd_addr), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check("rst_frame_done", int'(frame_done), 0);
      rst = 1'b0;
      idle(2);

      clear_logs(); pixel3(1, 1, 1'b0); idle(5);
      check_one("p11", 5, 90, 0);
      check("p11_rd", rd_cnt, 9);

      clear_logs(); pixel3(0, 0, 1'b1); idle(5);
      check_one("p00", 0, 40, 1);
      check("p00_rd", rd_cnt, 4);

      clear_logs(); pixel3(0, 1, 1'b0); idle(5);
      check_one("p01", 1, 60, 0);

      // Whole frame back-to-back, end_frame on the last pixel.
      frame_exp = '{40, 60, 60, 40, 60, 90, 90, 60, 60, 90, 90, 60, 40, 60, 60, 40};
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(frame_exp[i]));
      clear_logs();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            pixel3(r, c, (r == 3 && c == 3));
      idle(5);
      check("frame_count", wr_data_log.size(), 16);
      check("frame_rd", rd_cnt, 100);
      for (int i = 0; i < 16; i++) begin
         if (i < wr_data_log.size() && exp_q.size() > 0) begin
            check($sformatf("frame_addr%0d", i), wr_addr_log[i], i);
            check($sformatf("frame_data%0d", i), wr_data_log[i], int'(exp_q.pop_front()));
            check($sformatf("frame_fd%0d", i), wr_fd_log[i], (i == 15) ? 1 : 0);
         end
      end

      // Gap in the middle of a pixel: accumulator must hold.
      clear_logs();
      for (int k = 0; k < 5; k++) drive_tap(1, 2, k, 1'b0);
      idle(3);
      for (int k = 5; k < 9; k++) drive_tap(1, 2, k, 1'b0);
      idle(5);
      check_one("gap", 6, 90, 0);

      fill(255);
      clear_logs(); pixel3(1, 1, 1'b0); idle(5);
      check_one("sat11", 5, 255, 0);
      clear_logs(); pixel3(2, 2, 1'b0); idle(5);
      check_one("sat22", 10, 255, 0);
      clear_logs(); pixel3(0, 0, 1'b0); idle(5);
      check_one("sat00", 0, 255, 0);

      fill(10);
      set_weights(-1);
      clear_logs(); pixel3(1, 1, 1'b0); idle(5);
      check_one("relu", 5, 0, 0);
      bias = 16'd200;
      clear_logs(); pixel3(1, 1, 1'b0); idle(5);
      check_one("bias11", 5, 110, 0);
      clear_logs(); pixel3(0, 0, 1'b0); idle(5);
      check_one("bias00", 0, 160, 0);

      set_weights(1);
      bias  = 16'd0;
      shift = 4'd3;
      clear_logs(); pixel3(1, 1, 1'b0); idle(5);
      check_one("shift11", 5, 11, 0);
      clear_logs(); pixel3(0, 0, 1'b0); idle(5);
      check_one("shift00", 0, 5, 0);
      shift = 4'd0;

      // 1x1 mode: only the centre weight applies, pix_idx ignored.
      is_conv3x3 = 1'b0;
      set_weights(5);
      weight[39:32] = 8'd2;
      mem[11] = 8'd7;
      clear_logs();
      drive_tap(2, 3, 7, 1'b0);
      @(negedge clk); run = 1'b0;
      check("p1x1_rd_en", int'(rd_en), 1);
      check("p1x1_rd_addr", int'(rd_addr), 11);
      check("p1x1_wr_en_t1", int'(wr_en), 0);
      @(negedge clk);
      check("p1x1_wr_en_t2", int'(wr_en), 0);
      @(negedge clk);
      check("p1x1_wr_en_t3", int'(wr_en), 1);
      check("p1x1_wr_addr", int'(wr_addr), 11);
      check("p1x1_wr_data", int'(wr_data), 14);
      @(negedge clk);
      check("p1x1_wr_en_t4", int'(wr_en), 0);
      idle(2);

      mem[8] = 8'd3; mem[9] = 8'd100; mem[10] = 8'd200;
      clear_logs();
      drive_tap(2, 0, 0, 1'b0);
      drive_tap(2, 1, 0, 1'b0);
      drive_tap(2, 2, 0, 1'b1);
      idle(5);
      check("b2b_count", wr_data_log.size(), 3);
      if (wr_data_log.size() == 3) begin
         check("b2b_addr0", wr_addr_log[0], 8);
         check("b2b_data0", wr_data_log[0], 6);
         check("b2b_data1", wr_data_log[1], 200);
         check("b2b_data2", wr_data_log[2], 255);
         check("b2b_fd1", wr_fd_log[1], 0);
         check("b2b_fd2", wr_fd_log[2], 1);
      end

      // Reset in the middle of pixel (1,1): nothing is written for it.
      is_conv3x3 = 1'b1;
      set_weights(1);
      fill(10);
      clear_logs();
      for (int k = 0; k < 5; k++) drive_tap(1, 1, k, 1'b0);
      @(negedge clk); run = 1'b0; rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(6);
      check("rstmid_no_wr", wr_data_log.size(), 0);
      clear_logs(); pixel3(1, 1, 1'b0); idle(5);
      check_one("rstmid_after", 5, 90, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
